eco32_core_lsu_dcm_ptx: RTL
===========================

ECO32_CORE_LSU_DCM_PTX -- requirements
Module: eco32_core_lsu_dcm_ptx

Interface
REQ-001 SHALL have parameter CREDITS, default 4, initial network packet credits (1..15).
REQ-002 SHALL have parameter FORCE_RST, default 0, 1 = data registers also reset (else only control/state reset).
REQ-003 clk  input  1  single clock, all logic on rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 i_hdr_stb  input  1  header word valid from packet FIFO.
REQ-006 i_hdr_ack  output  1  one-cycle pulse: header consumed.
REQ-007 i_data_stb  input  1  payload word valid from packet FIFO.
REQ-008 i_data_flush  output  1  one-cycle pulse: payload word consumed.
REQ-009 i_data  input  72  header or payload word; header bits [67:64] = payload length LEN (0..8).
REQ-010 i_iid  input  4  issuing instance id.
REQ-011 o_stb  output  1  network word valid.
REQ-012 o_sof  output  1  word is packet header.
REQ-013 o_eof  output  1  word is last of packet.
REQ-014 o_data  output  72  network word.
REQ-015 o_iid  output  4  id of word.
REQ-016 o_ack  input  1  network accepts word while o_stb=1.
REQ-017 o_crd  input  1  one-cycle credit return (one packet).
REQ-018 o_err  output  1  one-cycle protocol-error pulse.

Function
REQ-019 State machine SHALL have states IDLE, HDR, PLD.
REQ-020 Output register SHALL be "free" when o_stb=0 or o_ack=1 in the same cycle.
REQ-021 IDLE->HDR: i_hdr_stb=1, credit>0, output free; same cycle i_hdr_ack=1, word loaded next edge with o_sof=1, o_eof=(LEN==0), credit decremented, remaining-count RC loaded with LEN.
REQ-022 HDR SHALL last exactly one cycle; ->PLD if RC>0, else ->IDLE.
REQ-023 In PLD: i_data_stb=1 and output free -> i_data_flush=1, word loaded with o_sof=0, o_eof=(RC==1), RC decremented; RC reaching 0 -> IDLE.
REQ-024 i_hdr_ack and i_data_flush SHALL never be asserted in the same cycle, and SHALL be combinational from state, strobes, o_ack, credit.
REQ-025 o_stb SHALL hold o_data/o_sof/o_eof/o_iid stable until o_ack; back-to-back words at full rate when o_ack=1 every cycle (except one HDR bubble cycle per packet).
REQ-026 Credit counter 4 bits, reset to CREDITS; o_crd with packet start same cycle -> unchanged; o_crd at 15 -> saturate, o_err pulse.
REQ-027 i_hdr_stb with credit=0 SHALL stall in IDLE without ack.
REQ-028 i_data_stb=1 in IDLE with i_hdr_stb=0 -> i_data_flush=1, word dropped, o_err pulse.
REQ-029 i_hdr_stb=1 in PLD -> no ack, o_err pulse once per packet, keep waiting for payload.
REQ-030 LEN>8 SHALL be clamped to 8 and o_err pulsed at header acceptance.
REQ-031 Latency: accepted input word appears on o_stb the next cycle.

Reset
REQ-032 rst=0 SHALL immediately force state=IDLE, o_stb=0, o_sof=0, o_eof=0, o_err=0, RC=0, credit=CREDITS; o_data=0, o_iid=0 when FORCE_RST=1, else unspecified.
REQ-033 Reset mid-packet SHALL abandon the packet; no ack/flush pulses while rst=0; first cycle after release is IDLE.

Verification
REQ-034 Header LEN=2 + 2 payload words, o_ack=1 -> o_stb words: hdr(sof=1), p0, p1(eof=1); one ack, two flushes; credit 4->3.
REQ-035 Header LEN=0 -> single word sof=1,eof=1; no flush; state back to IDLE after HDR cycle.
REQ-036 CREDITS=1, two LEN=0 headers, o_crd pulsed 10 cycles after first -> second header acked only after o_crd cycle.
REQ-037 o_ack=0 for 5 cycles during payload -> o_stb/o_data held constant, no flush until o_ack returns.
REQ-038 i_data_stb in IDLE -> flush pulse, o_err=1 one cycle, o_stb stays 0.
REQ-039 rst asserted during PLD with RC=3 -> o_stb=0 immediately; after release a new LEN=1 packet transmits correctly, credit=CREDITS-1.

Source files
------------

// File: rtl/eco32_core_lsu_dcm_ptx.sv
// Packet transmitter: moves header and payload words from the packet FIFO to the
// network through a single output register, with credit-based flow control.
module eco32_core_lsu_dcm_ptx #(
  parameter int unsigned CREDITS   = 4,
  parameter int unsigned FORCE_RST = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_hdr_stb,
  output logic        i_hdr_ack,
  input  logic        i_data_stb,
  output logic        i_data_flush,
  input  logic [71:0] i_data,
  input  logic [3:0]  i_iid,
  output logic        o_stb,
  output logic        o_sof,
  output logic        o_eof,
  output logic [71:0] o_data,
  output logic [3:0]  o_iid,
  input  logic        o_ack,
  input  logic        o_crd,
  output logic        o_err
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HDR  = 2'd1;
  localparam logic [1:0] ST_PLD  = 2'd2;

  localparam logic [3:0] CRED_INIT = 4'(CREDITS);
  localparam logic [3:0] LEN_MAX   = 4'd8;

  logic [1:0] state_q, state_d;
  logic [3:0] rc_q, rc_d;
  logic [3:0] credit_q, credit_d;
  logic       pld_err_q, pld_err_d;
  logic       err_d;
  logic       load_eof;

  logic       out_free;
  logic       hdr_take;
  logic       data_take;
  logic       drop_take;
  logic       load;
  logic [3:0] len_raw;
  logic [3:0] len_clamped;

  assign out_free    = !o_stb || o_ack;
  assign len_raw     = i_data[67:64];
  assign len_clamped = (len_raw > LEN_MAX) ? LEN_MAX : len_raw;

  // Handshakes are gated by reset so no FIFO word is consumed while held in reset.
  assign hdr_take  = rst && (state_q == ST_IDLE) && i_hdr_stb && (credit_q != '0) && out_free;
  assign drop_take = rst && (state_q == ST_IDLE) && !i_hdr_stb && i_data_stb;
  assign data_take = rst && (state_q == ST_PLD) && i_data_stb && out_free;

  assign i_hdr_ack    = hdr_take;
  assign i_data_flush = drop_take || data_take;
  assign load         = hdr_take || data_take;

  always_comb begin
    state_d   = state_q;
    rc_d      = rc_q;
    pld_err_d = pld_err_q;
    credit_d  = credit_q;
    err_d     = 1'b0;
    load_eof  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (hdr_take) begin
          state_d   = ST_HDR;
          rc_d      = len_clamped;
          pld_err_d = 1'b0;
          load_eof  = (len_clamped == '0);
          err_d     = (len_raw > LEN_MAX);
        end else if (drop_take) begin
          err_d = 1'b1;
        end
      end
      ST_HDR: begin
        state_d = (rc_q != '0) ? ST_PLD : ST_IDLE;
      end
      ST_PLD: begin
        if (data_take) begin
          load_eof = (rc_q == 4'd1);
          rc_d     = rc_q - 4'd1;
          if (rc_q == 4'd1) begin
            state_d = ST_IDLE;
          end
        end
        // A stray header during payload is flagged only once per packet.
        if (i_hdr_stb && !pld_err_q) begin
          err_d     = 1'b1;
          pld_err_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Simultaneous return and consumption cancel; returns beyond 15 are dropped.
    if (o_crd && !hdr_take) begin
      if (credit_q == 4'hf) begin
        err_d = 1'b1;
      end else begin
        credit_d = credit_q + 4'd1;
      end
    end else if (hdr_take && !o_crd) begin
      credit_d = credit_q - 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      rc_q      <= '0;
      credit_q  <= CRED_INIT;
      pld_err_q <= 1'b0;
      o_stb     <= 1'b0;
      o_sof     <= 1'b0;
      o_eof     <= 1'b0;
      o_err     <= 1'b0;
    end else begin
      state_q   <= state_d;
      rc_q      <= rc_d;
      credit_q  <= credit_d;
      pld_err_q <= pld_err_d;
      o_err     <= err_d;
      if (load) begin
        o_stb <= 1'b1;
        o_sof <= hdr_take;
        o_eof <= load_eof;
      end else if (o_ack) begin
        o_stb <= 1'b0;
      end
    end
  end

  if (FORCE_RST != 0) begin : g_data_rst
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        o_data <= '0;
        o_iid  <= '0;
      end else if (load) begin
        o_data <= i_data;
        o_iid  <= i_iid;
      end
    end
  end else begin : g_data_norst
    always_ff @(posedge clk) begin
      if (load) begin
        o_data <= i_data;
        o_iid  <= i_iid;
      end
    end
  end

endmodule
